// File: rtl/bus_pkg.sv
// Shared definitions for the on-chip burst bus agents.
//
// Contents:
//   DataBits       - width of the multiplexed address/data lines
//   ByteEnableBits - width of the per-byte write mask
//   BurstBits      - width of the burst-size field (words minus one)
//   busStateT      - state encoding of the SRAM bus responder
package bus_pkg;

    localparam int DataBits       = 32;
    localparam int ByteEnableBits = 4;
    localparam int BurstBits      = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_FETCH  = 3'd1,
        READ_BURST  = 3'd2,
        READ_END    = 3'd3,
        WRITE_BURST = 3'd4,
        ERROR_END   = 3'd5
    } busStateT;

endpackage

// File: rtl/sram_byte_we.sv
// Single-port synchronous SRAM with per-byte write enables.
// A read returns data one cycle after the enabled access. A write updates
// only the bytes whose enable bit is set and leaves readData untouched.
// Contents are never reset.
//
// Ports:
//   clock        in   system clock, rising edge
//   enable       in   access strobe; the array is idle when low
//   writeEnable  in   1 = write access, 0 = read access
//   byteEnables  in   per-byte write mask
//   address      in   word address
//   writeData    in   data to write
//   readData     out  registered read data
module sram_byte_we
    import bus_pkg::*;
#(
    parameter int nrOfEntries = 512,
    localparam int addrBits = $clog2(nrOfEntries)
) (
    input  logic                      clock,
    input  logic                      enable,
    input  logic                      writeEnable,
    input  logic [ByteEnableBits-1:0] byteEnables,
    input  logic [addrBits-1:0]       address,
    input  logic [DataBits-1:0]       writeData,
    output logic [DataBits-1:0]       readData
);

    logic [DataBits-1:0] memory [nrOfEntries];

    always_ff @(posedge clock) begin
        if (enable) begin
            if (writeEnable) begin
                for (int b = 0; b < ByteEnableBits; b++) begin
                    if (byteEnables[b]) begin
                        memory[address][8*b +: 8] <= writeData[8*b +: 8];
                    end
                end
            end else begin
                readData <= memory[address];
            end
        end
    end

endmodule

// File: rtl/bus_sram_slave.sv
// Burst-bus responder owning a word-addressed SRAM window.
// Serves single and burst reads/writes from any initiator. Bursts that would
// run past the end of the window are rejected with a one-cycle error pulse
// and never touch the memory.
//
// Ports:
//   clock              in   system clock, rising edge
//   reset              in   synchronous, active-high
//   beginTransactionIn in   start strobe; address on addressDataIn
//   readNotWriteIn     in   1 = read burst, 0 = write burst
//   byteEnablesIn      in   write byte mask for every word of the burst
//   burstSizeIn        in   number of words minus one
//   addressDataIn      in   address at begin, write data with dataValidIn
//   dataValidIn        in   write-data strobe
//   endTransactionIn   in   initiator ends a write or aborts a read
//   busErrorIn         in   error from another agent, aborts the transaction
//   addressDataOut     out  read data, zero whenever dataValidOut is low
//   dataValidOut       out  read-data strobe
//   endTransactionOut  out  end of a read burst or of a rejected read
//   busErrorOut        out  one-cycle error pulse
//   busyOut            out  write back-pressure (setup cycle)
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int          nrOfEntries = 512
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      beginTransactionIn,
    input  logic                      readNotWriteIn,
    input  logic [ByteEnableBits-1:0] byteEnablesIn,
    input  logic [BurstBits-1:0]      burstSizeIn,
    input  logic [DataBits-1:0]       addressDataIn,
    input  logic                      dataValidIn,
    input  logic                      endTransactionIn,
    input  logic                      busErrorIn,
    output logic [DataBits-1:0]       addressDataOut,
    output logic                      dataValidOut,
    output logic                      endTransactionOut,
    output logic                      busErrorOut,
    output logic                      busyOut
);

    localparam int addrBits = $clog2(nrOfEntries);
    // Wide enough that wordAddr + burstSize can never overflow.
    localparam int sumBits  = (addrBits > BurstBits) ? addrBits + 1 : BurstBits + 1;

    busStateT                  state, nextState;
    logic [addrBits-1:0]       wordAddr, nextWordAddr;
    logic [BurstBits:0]        remaining, nextRemaining;
    logic [ByteEnableBits-1:0] byteEnables, nextByteEnables;
    logic                      readNotWrite, nextReadNotWrite;
    logic                      nextDataValid, nextEnd, nextError, nextBusy;

    logic                      ramEnable, ramWrite;
    logic [DataBits-1:0]       ramReadData;

    logic                      hit, inRange;
    logic [sumBits-1:0]        lastWord;
    logic                      unusedAddrBits;

    assign hit      = addressDataIn[31:addrBits+2] == baseAddress[31:addrBits+2];
    assign lastWord = sumBits'(addressDataIn[addrBits+1:2]) + sumBits'(burstSizeIn);
    assign inRange  = lastWord <= sumBits'(nrOfEntries - 1);
    assign unusedAddrBits = ^addressDataIn[1:0];

    // Read data drives the wired-OR bus only while it is valid.
    assign addressDataOut = dataValidOut ? ramReadData : '0;

    sram_byte_we #(
        .nrOfEntries(nrOfEntries)
    ) sram (
        .clock       (clock),
        .enable      (ramEnable && !reset),
        .writeEnable (ramWrite),
        .byteEnables (byteEnables),
        .address     (wordAddr),
        .writeData   (addressDataIn),
        .readData    (ramReadData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            wordAddr          <= '0;
            remaining         <= '0;
            byteEnables       <= '0;
            readNotWrite      <= 1'b0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
            busyOut           <= 1'b0;
        end else begin
            state             <= nextState;
            wordAddr          <= nextWordAddr;
            remaining         <= nextRemaining;
            byteEnables       <= nextByteEnables;
            readNotWrite      <= nextReadNotWrite;
            dataValidOut      <= nextDataValid;
            endTransactionOut <= nextEnd;
            busErrorOut       <= nextError;
            busyOut           <= nextBusy;
        end
    end

    always_comb begin
        nextState        = state;
        nextWordAddr     = wordAddr;
        nextRemaining    = remaining;
        nextByteEnables  = byteEnables;
        nextReadNotWrite = readNotWrite;
        nextDataValid    = 1'b0;
        nextEnd          = 1'b0;
        nextError        = 1'b0;
        nextBusy         = 1'b0;
        ramEnable        = 1'b0;
        ramWrite         = 1'b0;

        case (state)
            IDLE: begin
                if (beginTransactionIn && hit) begin
                    nextWordAddr     = addressDataIn[addrBits+1:2];
                    nextRemaining    = {1'b0, burstSizeIn};
                    nextByteEnables  = byteEnablesIn;
                    nextReadNotWrite = readNotWriteIn;
                    if (!inRange) begin
                        nextError = 1'b1;
                        nextState = ERROR_END;
                    end else if (readNotWriteIn) begin
                        nextState = READ_FETCH;
                    end else begin
                        nextBusy  = 1'b1;
                        nextState = WRITE_BURST;
                    end
                end
            end

            // READ_FETCH issues the first word; READ_BURST prefetches the
            // next one while the current one is on the bus. remaining counts
            // words still to be issued after the first.
            READ_FETCH, READ_BURST: begin
                if (endTransactionIn) begin
                    nextState = IDLE;
                end else if (busErrorIn) begin
                    nextEnd   = 1'b1;
                    nextState = READ_END;
                end else if (state == READ_FETCH || remaining != '0) begin
                    ramEnable     = 1'b1;
                    nextDataValid = 1'b1;
                    nextWordAddr  = wordAddr + 1'b1;
                    if (state == READ_BURST) begin
                        nextRemaining = remaining - 1'b1;
                    end
                    nextState = READ_BURST;
                end else begin
                    nextEnd   = 1'b1;
                    nextState = READ_END;
                end
            end

            READ_END: begin
                nextState = IDLE;
            end

            // busyOut high marks the setup cycle, where write data is ignored.
            // remaining underflows to a negative count after the last word,
            // so its top bit flags an exhausted burst.
            WRITE_BURST: begin
                if (endTransactionIn) begin
                    nextState = IDLE;
                end else if (busErrorIn) begin
                    nextState = ERROR_END;
                end else if (dataValidIn && !busyOut) begin
                    if (remaining[BurstBits]) begin
                        nextError = 1'b1;
                        nextState = ERROR_END;
                    end else begin
                        ramEnable     = 1'b1;
                        ramWrite      = 1'b1;
                        nextWordAddr  = wordAddr + 1'b1;
                        nextRemaining = remaining - 1'b1;
                    end
                end
            end

            // A rejected read ends on its own; a write waits for the initiator.
            ERROR_END: begin
                if (endTransactionIn) begin
                    nextState = IDLE;
                end else if (readNotWrite) begin
                    nextEnd   = 1'b1;
                    nextState = READ_END;
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Self-checking bench for bus_sram_slave.
// Every transaction schedules the outputs it must produce, cycle by cycle,
// into expectation tables derived from the bus rules; a negedge process
// compares the DUT against those tables on every cycle and records what it saw
// so that directed scenarios can also be pinned against literal values.
module tb_bus_sram_slave;

    localparam logic [31:0] Base     = 32'h5000_0000;
    localparam int          Entries  = 512;
    localparam int          MaxSlots = 16384;

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn, readNotWriteIn, dataValidIn;
    logic        endTransactionIn, busErrorIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic [31:0] addressDataIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut, endTransactionOut, busErrorOut, busyOut;

    always #5 clock = ~clock;

    bus_sram_slave #(
        .baseAddress (Base),
        .nrOfEntries (Entries)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .beginTransactionIn (beginTransactionIn),
        .readNotWriteIn     (readNotWriteIn),
        .byteEnablesIn      (byteEnablesIn),
        .burstSizeIn        (burstSizeIn),
        .addressDataIn      (addressDataIn),
        .dataValidIn        (dataValidIn),
        .endTransactionIn   (endTransactionIn),
        .busErrorIn         (busErrorIn),
        .addressDataOut     (addressDataOut),
        .dataValidOut       (dataValidOut),
        .endTransactionOut  (endTransactionOut),
        .busErrorOut        (busErrorOut),
        .busyOut            (busyOut)
    );

    int edgeCount = 0;
    always @(posedge clock) edgeCount <= edgeCount + 1;

    logic        expDv [MaxSlots], expEnd [MaxSlots], expErr [MaxSlots], expBusy [MaxSlots];
    logic [31:0] expData [MaxSlots];
    logic        obsDv [MaxSlots], obsEnd [MaxSlots], obsErr [MaxSlots], obsBusy [MaxSlots];
    logic [31:0] obsData [MaxSlots];
    logic [31:0] modelMem [Entries];

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 0;
    int slot;

    // Write-burst bookkeeping of the reference model.
    int         txStart;
    bit         wrLive, wrDead;
    int         wrWord, wrLeft;
    logic [3:0] wrBe;

    always @(negedge clock) begin
        if (checking && edgeCount < MaxSlots) begin
            slot = edgeCount;
            obsDv[slot]   = dataValidOut;
            obsEnd[slot]  = endTransactionOut;
            obsErr[slot]  = busErrorOut;
            obsBusy[slot] = busyOut;
            obsData[slot] = addressDataOut;
            compared++;
            if ({dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut} !==
                {expDv[slot], expEnd[slot], expErr[slot], expBusy[slot], expData[slot]}) begin
                mismatched++;
                $display("[TB] FAIL cycle %0d outputs: got dv=%b end=%b err=%b busy=%b data=%h, want dv=%b end=%b err=%b busy=%b data=%h",
                         slot, dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut,
                         expDv[slot], expEnd[slot], expErr[slot], expBusy[slot], expData[slot]);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    function automatic bit isHit(input logic [31:0] a);
        return (a >= Base) && (a < Base + 32'(Entries * 4));
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a - Base) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] oldWord, input logic [31:0] newWord,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = oldWord;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newWord[8*b +: 8];
        return r;
    endfunction

    function automatic void clearFrom(input int s);
        for (int i = s; i < s + 300 && i < MaxSlots; i++) begin
            expDv[i] = 0; expEnd[i] = 0; expErr[i] = 0; expBusy[i] = 0; expData[i] = 0;
        end
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
        beginTransactionIn = 0; readNotWriteIn = 0; byteEnablesIn = 0; burstSizeIn = 0;
        addressDataIn = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) nextCycle();
    endtask

    task automatic applyStimulus(input bit beginT, input bit rnw, input logic [3:0] be,
                                 input logic [7:0] bs, input logic [31:0] ad, input bit dv,
                                 input bit endT, input bit busErr);
        beginTransactionIn = beginT; readNotWriteIn = rnw; byteEnablesIn = be; burstSizeIn = bs;
        addressDataIn = ad; dataValidIn = dv; endTransactionIn = endT; busErrorIn = busErr;
        nextCycle();
    endtask

    // Starts a transaction in the current cycle T and schedules its outputs.
    task automatic beginTxn(input logic [31:0] addr, input bit rnw, input int bs, input logic [3:0] be);
        int t;
        int w;
        t = edgeCount;
        txStart = t;
        wrLive = 0;
        if (isHit(addr)) begin
            w = wordOf(addr);
            if (w + bs > Entries - 1) begin
                expErr[t+1] = 1;
                if (rnw) expEnd[t+2] = 1;
                else begin wrLive = 1; wrDead = 1; end
            end else if (rnw) begin
                for (int i = 0; i <= bs; i++) begin
                    expDv[t+2+i]   = 1;
                    expData[t+2+i] = modelMem[w+i];
                end
                expEnd[t+3+bs] = 1;
            end else begin
                expBusy[t+1] = 1;
                wrLive = 1; wrDead = 0; wrWord = w; wrLeft = bs + 1; wrBe = be;
            end
        end
        applyStimulus(1, rnw, be, 8'(bs), addr, 0, 0, 0);
    endtask

    task automatic dataBeat(input logic [31:0] d);
        int t;
        t = edgeCount;
        if (wrLive && !wrDead && t >= txStart + 2) begin
            if (wrLeft > 0) begin
                modelMem[wrWord] = merge(modelMem[wrWord], d, wrBe);
                wrWord = (wrWord + 1) % Entries;
                wrLeft--;
            end else begin
                expErr[t+1] = 1;
                wrDead = 1;
            end
        end
        applyStimulus(0, 0, 0, 0, d, 1, 0, 0);
    endtask

    task automatic endWrite();
        wrLive = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic abortRead(input bit byError);
        int t;
        t = edgeCount;
        clearFrom(t + 1);
        if (byError) expEnd[t+1] = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, !byError, byError);
    endtask

    task automatic writeWords(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d0,
                              input int n);
        beginTxn(addr, 0, n - 1, be);
        idleCycles(1);
        for (int i = 0; i < n; i++) dataBeat(d0 + 32'(i) * 32'h11);
        endWrite();
        idleCycles(1);
    endtask

    int          tA, tB;
    logic [31:0] anyOut;

    initial begin
        for (int i = 0; i < MaxSlots; i++) begin
            expDv[i] = 0; expEnd[i] = 0; expErr[i] = 0; expBusy[i] = 0; expData[i] = 0;
        end
        reset = 1;
        beginTransactionIn = 0; readNotWriteIn = 0; byteEnablesIn = 0; burstSizeIn = 0;
        addressDataIn = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0;
        checking = 1;
        idleCycles(3);
        reset = 0;
        idleCycles(1);
        checkOutput("resetState", {27'd0, obsDv[2], obsEnd[2], obsErr[2], obsBusy[2]} | obsData[2], 32'h0);

        // Fill the whole window with known data.
        for (int half = 0; half < 2; half++) begin
            beginTxn(Base + 32'(half * 1024), 0, 255, 4'hF);
            idleCycles(1);
            for (int i = 0; i < 256; i++) dataBeat($urandom);
            endWrite();
            idleCycles(1);
        end

        // Four-word write at base+0x10.
        tA = edgeCount;
        beginTxn(Base + 32'h10, 0, 3, 4'hF);
        idleCycles(1);
        dataBeat(32'h11); dataBeat(32'h22); dataBeat(32'h33); dataBeat(32'h44);
        endWrite();
        idleCycles(1);
        checkOutput("writeBusyT1", 32'(obsBusy[tA+1]), 32'h1);
        checkOutput("writeBusyT2", 32'(obsBusy[tA+2]), 32'h0);
        anyOut = 0;
        for (int s = tA; s <= tA + 7; s++) anyOut |= 32'(obsErr[s]);
        checkOutput("writeNoError", anyOut, 32'h0);

        // Read it back.
        tA = edgeCount;
        beginTxn(Base + 32'h10, 1, 3, 4'hF);
        idleCycles(8);
        checkOutput("readWord0", obsData[tA+2], 32'h11);
        checkOutput("readWord1", obsData[tA+3], 32'h22);
        checkOutput("readWord2", obsData[tA+4], 32'h33);
        checkOutput("readWord3", obsData[tA+5], 32'h44);
        checkOutput("readValidT5", 32'(obsDv[tA+5]), 32'h1);
        checkOutput("readEndT5", 32'(obsEnd[tA+5]), 32'h0);
        checkOutput("readEndT6", 32'(obsEnd[tA+6]), 32'h1);
        checkOutput("readDataT6", obsData[tA+6], 32'h0);

        // Partial byte-enable write.
        writeWords(Base, 4'hF, 32'h1111_1111, 1);
        writeWords(Base, 4'b0011, 32'hAABB_CCDD, 1);
        tA = edgeCount;
        beginTxn(Base, 1, 0, 4'hF);
        idleCycles(4);
        checkOutput("partialWrite", obsData[tA+2], 32'h1111_CCDD);

        // Address just past the window: a miss.
        tA = edgeCount;
        beginTxn(Base + 32'(Entries * 4), 1, 3, 4'hF);
        idleCycles(10);
        anyOut = 0;
        for (int s = tA + 1; s <= tA + 10; s++)
            anyOut |= obsData[s] | 32'({obsDv[s], obsEnd[s], obsErr[s], obsBusy[s]});
        checkOutput("missQuiet", anyOut, 32'h0);

        // Out-of-range read at the last word.
        tA = edgeCount;
        beginTxn(Base + 32'((Entries - 1) * 4), 1, 1, 4'hF);
        idleCycles(5);
        checkOutput("oorReadErrT1", 32'(obsErr[tA+1]), 32'h1);
        checkOutput("oorReadErrT2", 32'(obsErr[tA+2]), 32'h0);
        checkOutput("oorReadEndT2", 32'(obsEnd[tA+2]), 32'h1);
        anyOut = 0;
        for (int s = tA + 1; s <= tA + 5; s++) anyOut |= 32'(obsDv[s]);
        checkOutput("oorReadNoData", anyOut, 32'h0);

        // Same as a write, followed by a read that proves the block is idle.
        tA = edgeCount;
        beginTxn(Base + 32'((Entries - 1) * 4), 0, 1, 4'hF);
        idleCycles(1);
        dataBeat(32'hDEAD_BEEF);
        idleCycles(2);
        endWrite();
        tB = edgeCount;
        beginTxn(Base + 32'h10, 1, 0, 4'hF);
        idleCycles(4);
        checkOutput("oorWriteErrT1", 32'(obsErr[tA+1]), 32'h1);
        checkOutput("oorWriteNoBusy", 32'(obsBusy[tA+1]), 32'h0);
        checkOutput("afterOorRead", obsData[tB+2], 32'h11);

        // Reset in the middle of an 8-word read, then a fresh read.
        tA = edgeCount;
        beginTxn(Base + 32'h10, 1, 7, 4'hF);
        idleCycles(2);
        reset = 1;
        clearFrom(edgeCount + 1);
        wrLive = 0;
        nextCycle();
        reset = 0;
        idleCycles(2);
        beginTxn(Base + 32'h10, 1, 0, 4'hF);
        idleCycles(4);
        checkOutput("preResetData", 32'(obsDv[tA+3]), 32'h1);
        anyOut = 0;
        for (int s = tA + 4; s <= tA + 7; s++)
            anyOut |= obsData[s] | 32'({obsDv[s], obsEnd[s], obsErr[s], obsBusy[s]});
        checkOutput("resetQuiet", anyOut, 32'h0);
        checkOutput("postResetData", obsData[tA+8], 32'h11);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            int kind, bs, w, extra;
            bit rnw;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            bs   = $urandom_range(0, 7);
            if (kind <= 2) begin
                w = $urandom_range(0, Entries - 1 - bs);
                beginTxn(Base + 32'(w * 4), 1, bs, 4'hF);
                extra = $urandom_range(0, 5);
                if (extra <= 1) begin
                    idleCycles($urandom_range(0, bs));
                    abortRead(extra == 0);
                    idleCycles(3);
                end else begin
                    idleCycles(bs + 4);
                end
            end else if (kind <= 5) begin
                w = $urandom_range(0, Entries - 1 - bs);
                beginTxn(Base + 32'(w * 4), 0, bs, 4'($urandom));
                if ($urandom_range(0, 1) == 1) dataBeat($urandom);
                else idleCycles(1);
                if ($urandom_range(0, 7) == 0) begin
                    if (wrLive) wrDead = 1;
                    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
                end
                extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                for (int i = 0; i < bs + 1 + extra; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        if ($urandom_range(0, 5) == 0)
                            applyStimulus(1, 1'($urandom), 4'hF, 8'($urandom), Base + 32'($urandom_range(0, 100) * 4), 0, 0, 0);
                        else
                            idleCycles(1);
                    end
                    dataBeat($urandom);
                end
                endWrite();
                idleCycles($urandom_range(0, 2));
            end else if (kind <= 7) begin
                bs  = $urandom_range(1, 255);
                w   = $urandom_range(Entries - bs, Entries - 1);
                rnw = 1'($urandom);
                beginTxn(Base + 32'(w * 4), rnw, bs, 4'hF);
                if (rnw) idleCycles(3);
                else begin
                    idleCycles($urandom_range(1, 3));
                    dataBeat($urandom);
                    endWrite();
                    idleCycles(1);
                end
            end else begin
                addr = (Base ^ (32'h800 << $urandom_range(0, 20))) | 32'($urandom_range(0, 2047));
                rnw  = 1'($urandom);
                beginTxn(addr, rnw, bs, 4'hF);
                idleCycles(1);
                dataBeat($urandom);
                endWrite();
                idleCycles(bs + 3);
            end
        end

        idleCycles(5);
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
